// File: rtl/alu_seq_param_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states, flag positions.
// The MULT state exists only when ALU_SEQ_MUL_EN is defined.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd2
    } state_t;
`endif

    localparam int unsigned FLG_CARRY = 0;
    localparam int unsigned FLG_ZERO  = 1;
    localparam int unsigned FLG_NEG   = 2;
    localparam int unsigned FLG_OVF   = 3;
    localparam int unsigned FLG_ERR   = 4;
    localparam int unsigned NFLAGS    = 5;

endpackage

// File: rtl/alu_seq_param_if.sv
// Operand-issue / result-writeback bus of the sequential ALU.
// master = issue logic + writeback consumer, slave = the ALU.
interface alu_seq_param_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             neg;
    logic             ovf;
    logic             err;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, carry, zero, neg, ovf, err
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, carry, zero, neg, ovf, err
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial product per clock, WIDTH clocks.
// done is asserted during the final step; product then carries the completed value.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int unsigned CW = $clog2(WIDTH);

    logic               busy_q;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [CW-1:0]      cnt;

    // accumulate the current partial product; product is exposed combinationally so the
    // last step lands in the caller's registers on the same edge it is computed
    always_comb begin
        acc_nxt = acc + (mplier[0] ? mcand : '0);
    end

    assign busy    = busy_q;
    assign done    = busy_q & (cnt == CW'(WIDTH - 1));
    assign product = acc_nxt;

    // operand load on start, then shift multiplicand left / multiplier right each step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (busy_q) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/alu_seq_param.sv
// Registered WIDTH-bit ALU with valid/ready handshakes on input and output.
// Optional feature macro: ALU_SEQ_MUL_EN enables the iterative multiplier (op 111);
// without it op 111 completes in one clock with err=1 and result=0.
module alu_seq_param
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    localparam int unsigned SHW  = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    alu_seq_param_if.slave bus
);
    state_t            state, state_n;
    logic              in_ready_c;
    logic              accept;
    logic [WIDTH-1:0]  res_c, res_q;
    logic [NFLAGS-1:0] flg_c, flg_q;
    logic [WIDTH:0]    sum, dif, shl_w, shr_w;
    logic [SHW-1:0]    sh;

`ifdef ALU_SEQ_MUL_EN
    logic               is_mul;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [NFLAGS-1:0]  mul_flg;

    assign is_mul = (bus.op == OP_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept & is_mul),
        .a       (bus.a),
        .b       (bus.b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    // flags for the completed product
    always_comb begin
        mul_flg            = '0;
        mul_flg[FLG_CARRY] = |mul_prod[2*WIDTH-1:WIDTH];
        mul_flg[FLG_ZERO]  = (mul_prod[WIDTH-1:0] == '0);
        mul_flg[FLG_NEG]   = mul_prod[WIDTH-1];
    end

    assign in_ready_c = ~rst & ~mul_busy & ((state == IDLE) | ((state == DONE) & bus.out_ready));
`else
    assign in_ready_c = ~rst & ((state == IDLE) | ((state == DONE) & bus.out_ready));
`endif

    assign accept       = bus.in_valid & in_ready_c;
    assign bus.in_ready = in_ready_c;
    assign bus.out_valid = (state == DONE);
    assign bus.result   = res_q;
    assign bus.carry    = flg_q[FLG_CARRY];
    assign bus.zero     = flg_q[FLG_ZERO];
    assign bus.neg      = flg_q[FLG_NEG];
    assign bus.ovf      = flg_q[FLG_OVF];
    assign bus.err      = flg_q[FLG_ERR];

    // single-cycle datapath: result and flags for the presented op
    always_comb begin
        sh    = bus.b[SHW-1:0];
        sum   = {1'b0, bus.a} + {1'b0, bus.b};
        dif   = {1'b0, bus.a} - {1'b0, bus.b};
        // the extra bit above/below a catches the last bit shifted out; amount 0 leaves it 0
        shl_w = {1'b0, bus.a} << sh;
        shr_w = {bus.a, 1'b0} >> sh;
        res_c = '0;
        flg_c = '0;
        case (bus.op)
            OP_ADD: begin
                res_c            = sum[WIDTH-1:0];
                flg_c[FLG_CARRY] = sum[WIDTH];
                flg_c[FLG_OVF]   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &
                                   (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                res_c            = dif[WIDTH-1:0];
                flg_c[FLG_CARRY] = dif[WIDTH];
                flg_c[FLG_OVF]   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &
                                   (dif[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND: res_c = bus.a & bus.b;
            OP_OR:  res_c = bus.a | bus.b;
            OP_XOR: res_c = bus.a ^ bus.b;
            OP_SHL: begin
                res_c            = shl_w[WIDTH-1:0];
                flg_c[FLG_CARRY] = shl_w[WIDTH];
            end
            OP_SHR: begin
                res_c            = shr_w[WIDTH:1];
                flg_c[FLG_CARRY] = shr_w[0];
            end
            OP_MUL: begin
`ifndef ALU_SEQ_MUL_EN
                flg_c[FLG_ERR] = 1'b1;
`endif
            end
            default: ;
        endcase
        flg_c[FLG_ZERO] = (res_c == '0);
        flg_c[FLG_NEG]  = res_c[WIDTH-1];
    end

    // next-state: a new accept from DONE bypasses IDLE to keep 1/clk throughput
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                    state_n = is_mul ? MULT : DONE;
`else
                    state_n = DONE;
`endif
                end
            end
`ifdef ALU_SEQ_MUL_EN
            MULT: begin
                if (mul_done) begin
                    state_n = DONE;
                end
            end
`endif
            DONE: begin
                if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                    state_n = is_mul ? MULT : DONE;
`else
                    state_n = DONE;
`endif
                end else if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // output registers update only when a result completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
            flg_q <= '0;
`ifdef ALU_SEQ_MUL_EN
        end else if (accept && !is_mul) begin
            res_q <= res_c;
            flg_q <= flg_c;
        end else if ((state == MULT) && mul_done) begin
            res_q <= mul_prod[WIDTH-1:0];
            flg_q <= mul_flg;
`else
        end else if (accept) begin
            res_q <= res_c;
            flg_q <= flg_c;
`endif
        end
    end
endmodule

// File: tb/tb_alu_seq_param.sv
// Self-checking bench for alu_seq_param (WIDTH=4); follows ALU_SEQ_MUL_EN like the design.
module tb_alu_seq_param;
    import alu_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_param_if #(.WIDTH(W)) bus ();

    alu_seq_param #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [W+4:0] sbq[$];
    logic [W+4:0] exp_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // reference model: {result, carry, zero, neg, ovf, err}
    function automatic logic [W+4:0] model(input logic [2:0] op, input int a, input int b);
        int m, half, r, sa, sb, s, amt, p;
        logic c, v, e;
        m = 1 << W; half = m / 2;
        sa = (a >= half) ? a - m : a;
        sb = (b >= half) ? b - m : b;
        amt = b % W;
        r = 0; c = 0; v = 0; e = 0;
        case (op)
            OP_ADD: begin r = a + b; c = (r >= m); r = r % m; s = sa + sb; v = (s > half - 1) || (s < -half); end
            OP_SUB: begin c = (a < b); r = (a + m - b) % m; s = sa - sb; v = (s > half - 1) || (s < -half); end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SHL: begin r = (a << amt) % m; c = (amt == 0) ? 1'b0 : 1'(((a >> (W - amt)) & 1)); end
            OP_SHR: begin r = a >> amt; c = (amt == 0) ? 1'b0 : 1'(((a >> (amt - 1)) & 1)); end
            default: begin
`ifdef ALU_SEQ_MUL_EN
                p = a * b; r = p % m; c = (p >= m);
`else
                p = 0; r = 0; e = 1;
`endif
            end
        endcase
        return {r[W-1:0], c, (r == 0), (r >= half), v, e};
    endfunction

    // scoreboard: pop/compare on output hand-off, push on input accept
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    chk("sb_underflow", bus.out_valid, 0);
                end else begin
                    exp_v = sbq.pop_front();
                    chk("sb", {bus.result, bus.carry, bus.zero, bus.neg, bus.ovf, bus.err}, exp_v);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sbq.push_back(model(bus.op, int'(bus.a), int'(bus.b)));
            end
        end
    end

    // present one op, wait for accept, then for out_valid; returns latency and in_ready seen while busy
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int ir_busy);
        int n;
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.in_ready && n < 50);
        chk("accept", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0; ir_busy = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin lat = k; break; end
            if (bus.in_ready) ir_busy++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, irb;
        logic [2:0] tops [6];
        tops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL};

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.a = '0; bus.b = '0; bus.op = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_outputs", {bus.result, bus.carry, bus.zero, bus.neg, bus.ovf, bus.err}, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", bus.in_ready, 1);
        chk("idle_out_valid", bus.out_valid, 0);

        send(OP_ADD, 4'b0101, 4'b0011, lat, irb);
        chk("add_lat", lat, 1);
        chk("add_res", {bus.result, bus.carry, bus.ovf, bus.neg, bus.zero}, {4'b1000, 4'b0110});

        send(OP_SUB, 4'b1001, 4'b0010, lat, irb);
        chk("sub1_res", {bus.result, bus.carry, bus.ovf}, {4'b0111, 2'b01});
        send(OP_SUB, 4'b0010, 4'b0011, lat, irb);
        chk("sub2_res", {bus.result, bus.carry, bus.neg}, {4'b1111, 2'b11});
        send(OP_SHL, 4'b1100, 4'b0001, lat, irb);
        chk("shl_res", {bus.result, bus.carry}, {4'b1000, 1'b1});
        send(OP_SHR, 4'b0011, 4'b0010, lat, irb);
        chk("shr_res", {bus.result, bus.carry, bus.zero}, {4'b0000, 2'b11});
        send(OP_SHL, 4'b1011, 4'b0100, lat, irb);
        chk("shl_amt0", {bus.result, bus.carry}, {4'b1011, 1'b0});

        send(OP_MUL, 4'b0111, 4'b0011, lat, irb);
`ifdef ALU_SEQ_MUL_EN
        chk("mul_lat", lat, 5);
        chk("mul_in_ready_busy", irb, 0);
        chk("mul_res", {bus.result, bus.carry, bus.err}, {4'b0101, 2'b10});
`else
        chk("mul_lat", lat, 1);
        chk("mul_res", {bus.result, bus.carry, bus.ovf, bus.zero, bus.neg, bus.err}, {4'b0000, 5'b00101});
`endif

        for (int i = 0; i < 16; i++) begin
            send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), lat, irb);
        end

        // backpressure
        @(posedge clk); #1 bus.out_ready = 1'b0;
        send(OP_AND, 4'b1100, 4'b1010, lat, irb);
        repeat (3) @(negedge clk);
        chk("bp_hold_res", bus.result, 4'b1000);
        chk("bp_hold_valid", bus.out_valid, 1);
        chk("bp_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.op = OP_ADD; bus.a = 4'b0001; bus.b = 4'b0001;
        @(negedge clk);
        chk("bp_pending_ready", bus.in_ready, 0);
        chk("bp_pending_res", bus.result, 4'b1000);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(negedge clk);
        chk("handoff_ready", bus.in_ready, 1);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk("handoff_next", {bus.out_valid, bus.result}, {1'b1, 4'b0010});

        // back-to-back single-cycle throughput
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1; bus.op = tops[i];
            bus.a = 4'($urandom_range(0, 15)); bus.b = 4'($urandom_range(0, 15));
            @(negedge clk);
            chk("tput_ready", bus.in_ready, 1);
            if (i > 0) chk("tput_valid", bus.out_valid, 1);
        end
        @(posedge clk); #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk("tput_last_valid", bus.out_valid, 1);

        // reset two clocks into a multiply
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.op = OP_MUL; bus.a = 4'b0111; bus.b = 4'b0011;
        @(negedge clk);
        chk("rmul_accept", bus.in_ready, 1);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("rmul_out_valid", bus.out_valid, 0);
        chk("rmul_outputs", {bus.result, bus.carry, bus.zero, bus.neg, bus.ovf, bus.err}, 0);
        chk("rmul_in_ready", bus.in_ready, 0);
        sbq.delete();
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_valid", bus.out_valid, 0);
            chk("post_rst_ready", bus.in_ready, 1);
        end
        send(OP_OR, 4'b0101, 4'b0010, lat, irb);
        chk("post_rst_op", {bus.result, lat[3:0]}, {4'b0111, 4'd1});

        @(negedge clk);
        chk("sb_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
